axi_arbiter_stom_s2: RTL and testbench

- Slave-to-master response arbiter for one AXI master port. Merges the read-data (R) and write-response (B) channels of two slave ports onto that master.
- It is the return-path counterpart of the master-to-slave request arbiter, and sits in the interconnect next to each master's response mux.
- An R burst is granted atomically: the grant is held until the RLAST handshake. A B response is granted until its single-beat handshake.
- Arbitration is round-robin, or fixed priority when the parameter selects it.

---
 rtl/axi_arbiter_stom_s2.sv | 163 ++++++++++++++++
 tb/tb_axi_arbiter_stom_s2.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/axi_arbiter_stom_s2.sv
// Slave-to-master response arbiter: merges the R and B channels of two slave
// ports onto one master port. R bursts are granted atomically until RLAST
// handshakes; B responses are held until their single-beat handshake.
// Round-robin or fixed-priority (slave 0 highest) tie-breaking.
module axi_arbiter_stom_s2 #(
    parameter int NUM         = 2,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic           ACLK,
    input  logic           ARESET,
    input  logic [NUM-1:0] RSELECT,
    input  logic [NUM-1:0] RVALID,
    input  logic [NUM-1:0] RLAST,
    input  logic           RREADY,
    output logic [NUM-1:0] RGRANT,
    input  logic [NUM-1:0] BSELECT,
    input  logic [NUM-1:0] BVALID,
    input  logic           BREADY,
    output logic [NUM-1:0] BGRANT
);

    typedef enum logic {R_IDLE = 1'b0, R_BUSY = 1'b1} r_state_t;
    typedef enum logic {B_IDLE = 1'b0, B_WAIT = 1'b1} b_state_t;

    r_state_t       r_state_r, r_state_nxt_s;
    b_state_t       b_state_r, b_state_nxt_s;
    logic [NUM-1:0] rgrant_reg_r, rgrant_reg_nxt_s;
    logic [NUM-1:0] bgrant_reg_r, bgrant_reg_nxt_s;
    logic           r_last_r, r_last_nxt_s;
    logic           b_last_r, b_last_nxt_s;
    logic [NUM-1:0] req_r_s, req_b_s;
    logic [NUM-1:0] rgrant_s, bgrant_s;

    // Pick a winner: single requester wins outright; on a tie either the slave
    // that was not served last (round-robin) or slave 0 (fixed priority).
    function automatic logic [NUM-1:0] sel_f(input logic [NUM-1:0] req, input logic last);
        logic [NUM-1:0] gnt;
        case (req)
            2'b00:   gnt = 2'b00;
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
                if (ROUND_ROBIN) begin
                    gnt = last ? 2'b01 : 2'b10;
                end else begin
                    gnt = 2'b01;
                end
            end
            default: gnt = 2'b00;
        endcase
        return gnt;
    endfunction

    assign req_r_s = RSELECT & RVALID;
    assign req_b_s = BSELECT & BVALID;
    assign RGRANT  = rgrant_s;
    assign BGRANT  = bgrant_s;

    // R channel: next-state and grant; grant is forced low while in reset.
    always_comb begin
        rgrant_s         = 2'b00;
        r_state_nxt_s    = r_state_r;
        rgrant_reg_nxt_s = rgrant_reg_r;
        r_last_nxt_s     = r_last_r;
        if (ARESET) begin
            rgrant_s = 2'b00;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    rgrant_s = sel_f(req_r_s, r_last_r);
                    if (rgrant_s != 2'b00) begin
                        if ((|(rgrant_s & RVALID)) && RREADY && (|(rgrant_s & RLAST))) begin
                            // Single-beat burst completes immediately.
                            r_last_nxt_s = rgrant_s[1];
                        end else begin
                            rgrant_reg_nxt_s = rgrant_s;
                            r_state_nxt_s    = R_BUSY;
                        end
                    end else begin
                        r_state_nxt_s = R_IDLE;
                    end
                end
                R_BUSY: begin
                    rgrant_s = rgrant_reg_r;
                    if ((|(rgrant_s & RVALID)) && RREADY && (|(rgrant_s & RLAST))) begin
                        r_last_nxt_s     = rgrant_reg_r[1];
                        rgrant_reg_nxt_s = 2'b00;
                        r_state_nxt_s    = R_IDLE;
                    end else begin
                        r_state_nxt_s = R_BUSY;
                    end
                end
                default: begin
                    rgrant_s         = 2'b00;
                    rgrant_reg_nxt_s = 2'b00;
                    r_state_nxt_s    = R_IDLE;
                end
            endcase
        end
    end

    // B channel: next-state and grant; a stalled response pins the grant.
    always_comb begin
        bgrant_s         = 2'b00;
        b_state_nxt_s    = b_state_r;
        bgrant_reg_nxt_s = bgrant_reg_r;
        b_last_nxt_s     = b_last_r;
        if (ARESET) begin
            bgrant_s = 2'b00;
        end else begin
            case (b_state_r)
                B_IDLE: begin
                    bgrant_s = sel_f(req_b_s, b_last_r);
                    if (bgrant_s != 2'b00) begin
                        if ((|(bgrant_s & BVALID)) && BREADY) begin
                            b_last_nxt_s = bgrant_s[1];
                        end else begin
                            bgrant_reg_nxt_s = bgrant_s;
                            b_state_nxt_s    = B_WAIT;
                        end
                    end else begin
                        b_state_nxt_s = B_IDLE;
                    end
                end
                B_WAIT: begin
                    bgrant_s = bgrant_reg_r;
                    if ((|(bgrant_s & BVALID)) && BREADY) begin
                        b_last_nxt_s     = bgrant_reg_r[1];
                        bgrant_reg_nxt_s = 2'b00;
                        b_state_nxt_s    = B_IDLE;
                    end else begin
                        b_state_nxt_s = B_WAIT;
                    end
                end
                default: begin
                    bgrant_s         = 2'b00;
                    bgrant_reg_nxt_s = 2'b00;
                    b_state_nxt_s    = B_IDLE;
                end
            endcase
        end
    end

    // State, held grants and last-served pointers; last=1 so slave 0 wins first tie.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state_r    <= R_IDLE;
            b_state_r    <= B_IDLE;
            rgrant_reg_r <= 2'b00;
            bgrant_reg_r <= 2'b00;
            r_last_r     <= 1'b1;
            b_last_r     <= 1'b1;
        end else begin
            r_state_r    <= r_state_nxt_s;
            b_state_r    <= b_state_nxt_s;
            rgrant_reg_r <= rgrant_reg_nxt_s;
            bgrant_reg_r <= bgrant_reg_nxt_s;
            r_last_r     <= r_last_nxt_s;
            b_last_r     <= b_last_nxt_s;
        end
    end

endmodule

// File: tb/tb_axi_arbiter_stom_s2.sv
// Randomized bench for axi_arbiter_stom_s2: a round-robin and a fixed-priority
// instance share the same stimulus; each is compared against a transaction-level
// owner/last-served model every cycle.
module tb_axi_arbiter_stom_s2;

    logic       ACLK = 1'b0;
    logic       ARESET = 1'b1;
    logic [1:0] RSELECT = 2'b00, RVALID = 2'b00, RLAST = 2'b00;
    logic       RREADY = 1'b0;
    logic [1:0] BSELECT = 2'b00, BVALID = 2'b00;
    logic       BREADY = 1'b0;
    logic [1:0] rgrant_rr, bgrant_rr, rgrant_fp, bgrant_fp;

    int n_checks = 0;
    int n_pass   = 0;

    // model state per instance (0 = round-robin, 1 = fixed priority)
    int r_own [2];
    int r_lst [2];
    int b_own [2];
    int b_lst [2];

    always #5 ACLK = ~ACLK;

    axi_arbiter_stom_s2 #(.NUM(2), .ROUND_ROBIN(1'b1)) u_rr (
        .ACLK(ACLK), .ARESET(ARESET),
        .RSELECT(RSELECT), .RVALID(RVALID), .RLAST(RLAST), .RREADY(RREADY), .RGRANT(rgrant_rr),
        .BSELECT(BSELECT), .BVALID(BVALID), .BREADY(BREADY), .BGRANT(bgrant_rr)
    );

    axi_arbiter_stom_s2 #(.NUM(2), .ROUND_ROBIN(1'b0)) u_fp (
        .ACLK(ACLK), .ARESET(ARESET),
        .RSELECT(RSELECT), .RVALID(RVALID), .RLAST(RLAST), .RREADY(RREADY), .RGRANT(rgrant_fp),
        .BSELECT(BSELECT), .BVALID(BVALID), .BREADY(BREADY), .BGRANT(bgrant_fp)
    );

    task automatic check_val(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%b exp=%b at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Winner index among requesters, -1 if nobody asks.
    function automatic int pick(input logic [1:0] req, input int last, input bit rr);
        if (req == 2'b00) return -1;
        if (req == 2'b01) return 0;
        if (req == 2'b10) return 1;
        if (rr) return 1 - last;
        return 0;
    endfunction

    function automatic logic [1:0] onehot(input int idx);
        logic [1:0] v;
        v = 2'b00;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            r_own[k] = -1; r_lst[k] = 1;
            b_own[k] = -1; b_lst[k] = 1;
        end
    endtask

    // Compare both instances this cycle, then advance the model past the next edge.
    task automatic check_and_step();
        int ri, bi;
        logic [1:0] rg, bg;
        for (int k = 0; k < 2; k++) begin
            ri = (r_own[k] >= 0) ? r_own[k] : pick(RSELECT & RVALID, r_lst[k], (k == 0));
            bi = (b_own[k] >= 0) ? b_own[k] : pick(BSELECT & BVALID, b_lst[k], (k == 0));
            rg = (k == 0) ? rgrant_rr : rgrant_fp;
            bg = (k == 0) ? bgrant_rr : bgrant_fp;
            check_val((k == 0) ? "rgrant_rr" : "rgrant_fp", rg, onehot(ri));
            check_val((k == 0) ? "bgrant_rr" : "bgrant_fp", bg, onehot(bi));
            if (ri >= 0) begin
                if (RVALID[ri] && RREADY && RLAST[ri]) begin
                    r_own[k] = -1; r_lst[k] = ri;
                end else begin
                    r_own[k] = ri;
                end
            end
            if (bi >= 0) begin
                if (BVALID[bi] && BREADY) begin
                    b_own[k] = -1; b_lst[k] = bi;
                end else begin
                    b_own[k] = bi;
                end
            end
        end
    endtask

    task automatic drive_random();
        RSELECT = ($urandom_range(0, 9) < 8) ? 2'b11 : 2'($urandom);
        RVALID  = 2'($urandom);
        RLAST   = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
        RREADY  = ($urandom_range(0, 3) != 0);
        BSELECT = ($urandom_range(0, 9) < 8) ? 2'b11 : 2'($urandom);
        BVALID  = 2'($urandom);
        BREADY  = ($urandom_range(0, 2) != 0);
    endtask

    initial begin
        model_reset();
        // grants stay low during reset even with requests present
        RSELECT = 2'b11; RVALID = 2'b11; BSELECT = 2'b11; BVALID = 2'b11;
        RREADY = 1'b1; BREADY = 1'b1; RLAST = 2'b11;
        #1;
        check_val("reset_rgrant", rgrant_rr, 2'b00);
        check_val("reset_bgrant", bgrant_fp, 2'b00);
        @(negedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;

        // directed: 4-beat burst from slave 0, then tie goes to slave 1 (rr)
        RSELECT = 2'b11; RVALID = 2'b01; RREADY = 1'b1; RLAST = 2'b00;
        BVALID = 2'b00;
        for (int b = 0; b < 4; b++) begin
            RLAST = (b == 3) ? 2'b01 : 2'b00;
            #1;
            check_and_step();
            @(negedge ACLK);
        end
        RVALID = 2'b11; RLAST = 2'b00;
        #1;
        check_val("rr_after_burst", rgrant_rr, 2'b10);
        check_and_step();
        @(negedge ACLK);

        // directed: stalled B response from slave 1 pins the grant
        RVALID = 2'b00; BSELECT = 2'b11; BVALID = 2'b10; BREADY = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) BVALID = 2'b11;
            if (c == 3) BREADY = 1'b1;
            #1;
            check_and_step();
            @(negedge ACLK);
        end

        // randomized traffic with a mid-run asynchronous reset
        for (int i = 0; i < 400; i++) begin
            drive_random();
            if (i == 200) begin
                ARESET = 1'b1;
                #1;
                check_val("midrun_reset_r", rgrant_rr, 2'b00);
                check_val("midrun_reset_b", bgrant_rr, 2'b00);
                model_reset();
                @(negedge ACLK);
                ARESET = 1'b0;
                RSELECT = 2'b11; RVALID = 2'b11; RLAST = 2'b00;
                #1;
                check_val("post_reset_tie", rgrant_rr, 2'b01);
            end else begin
                #1;
            end
            check_and_step();
            @(negedge ACLK);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
